alu_dp_sequencer: RTL and testbench

- Sequences one ARM data-processing instruction at a time through the shared 32-bit ALU (4-bit FN opcode, CIN, COUT, V).
- Per instruction: accepts the decoded operands, checks the condition field against the NZCV flags register it owns, drives the ALU, and captures the result.
- Raises a register-file write enable for non-compare ops and updates NZCV when S=1 or the op is TST/TEQ/CMP/CMN.
- Sits between the decode stage and the register file / CPSR in the multi-cycle core.

---
 rtl/alu_pkg.sv | 76 +++++++
 rtl/alu_cond_check.sv | 47 ++++
 rtl/alu_dp_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_dp_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the data-processing sequencer and the condition
// checker (the branch unit reuses the condition checker):
//   - ARM data-processing opcode constants (AND..MVN)
//   - ARM condition-field constants (EQ..NV)
//   - NZCV bit indices inside the 4-bit flags word
//   - sequencer state encoding
//   - classify_op(): arithmetic / compare-only / carry-in-consuming opcodes
// ---------------------------------------------------------------------------
package alu_pkg;

  // Data-processing opcodes, forwarded unchanged as the ALU FN code.
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_RSC = 4'b0111;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // Condition field encodings.
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Bit positions inside the {N,Z,C,V} flags word.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic arith;     // C/V come from the ALU
    logic compare;   // flags only, no register write
    logic uses_cin;  // ALU consumes the current C flag
  } op_class_t;

  function automatic op_class_t classify_op(input logic [3:0] op);
    op_class_t cls;
    cls.compare  = (op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN});
    cls.arith    = (op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC,
                               OP_SBC, OP_RSC, OP_CMP, OP_CMN});
    cls.uses_cin = (op inside {OP_ADC, OP_SBC, OP_RSC});
    return cls;
  endfunction

endpackage

// File: rtl/alu_cond_check.sv
// ---------------------------------------------------------------------------
// alu_cond_check
// Purely combinational ARM condition evaluator.
//   cond  in  4  ARM condition field
//   nzcv  in  4  current flags {N,Z,C,V}
//   pass  out 1  1 when the instruction should execute
// ---------------------------------------------------------------------------
module alu_cond_check
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    // NOTE: every output of a combinational block gets a default before the
    // case so no path leaves it unassigned (which would infer a latch).
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;  // NV never executes
    endcase
  end

endmodule

// File: rtl/alu_dp_sequencer.sv
// ---------------------------------------------------------------------------
// alu_dp_sequencer
// Runs one ARM data-processing instruction at a time through the shared ALU
// and owns the NZCV flags register. Flow: IDLE -> EXEC -> WB -> IDLE.
// START accepted at edge t gives DONE/RD_WE/FLAGS after edge t+2.
//
// Ports
//   CLK, RESET_N                 clock, synchronous active-low reset
//   START                        request, sampled only while idle
//   COND, OPCODE, S_BIT          decoded instruction fields
//   RN_VAL, OP2_VAL, SHIFTER_C   operands and shifter carry-out
//   ALU_LEFT/RIGHT/FN/CIN        registered drive to the shared ALU
//   ALU_RESULT/COUT/V            ALU response, captured at the end of EXEC
//   BUSY                         high outside IDLE
//   DONE, SKIPPED, RD_WE         one-cycle completion strobes
//   RD_DATA                      last written result
//   FLAGS                        NZCV register {N,Z,C,V}
// ---------------------------------------------------------------------------
module alu_dp_sequencer
  import alu_pkg::*;
#(
  parameter int         DATA_W    = 32,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [3:0]        COND,
  input  logic [3:0]        OPCODE,
  input  logic              S_BIT,
  input  logic [DATA_W-1:0] RN_VAL,
  input  logic [DATA_W-1:0] OP2_VAL,
  input  logic              SHIFTER_C,
  output logic [DATA_W-1:0] ALU_LEFT,
  output logic [DATA_W-1:0] ALU_RIGHT,
  output logic [3:0]        ALU_FN,
  output logic              ALU_CIN,
  input  logic [DATA_W-1:0] ALU_RESULT,
  input  logic              ALU_COUT,
  input  logic              ALU_V,
  output logic              BUSY,
  output logic              DONE,
  output logic              SKIPPED,
  output logic              RD_WE,
  output logic [DATA_W-1:0] RD_DATA,
  output logic [3:0]        FLAGS
);

  state_e            state;
  logic              cond_pass;
  logic              pass_q;
  logic              s_q;
  logic              shc_q;
  logic [DATA_W-1:0] res_q;
  logic              cout_q;
  logic              v_q;
  op_class_t         cls_in;
  op_class_t         cls_q;
  logic [3:0]        next_flags;

  // Condition is judged against FLAGS at the accept edge; a new instruction
  // can only be accepted after the previous WB, so FLAGS are already final.
  alu_cond_check u_cond_check (
    .cond (COND),
    .nzcv (FLAGS),
    .pass (cond_pass)
  );

  assign cls_in = classify_op(OPCODE);
  // ALU_FN doubles as the latched opcode for the rest of the instruction.
  assign cls_q  = classify_op(ALU_FN);

  always_comb begin
    next_flags         = FLAGS;
    next_flags[FLAG_N] = res_q[DATA_W-1];
    next_flags[FLAG_Z] = (res_q == '0);
    if (cls_q.arith) begin
      next_flags[FLAG_C] = cout_q;
      next_flags[FLAG_V] = v_q;
    end else begin
      next_flags[FLAG_C] = shc_q;  // logical ops keep V
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      FLAGS     <= FLAGS_RST;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      SKIPPED   <= 1'b0;
      RD_WE     <= 1'b0;
      RD_DATA   <= '0;
      ALU_LEFT  <= '0;
      ALU_RIGHT <= '0;
      ALU_FN    <= OP_AND;
      ALU_CIN   <= 1'b0;
      pass_q    <= 1'b0;
      s_q       <= 1'b0;
      shc_q     <= 1'b0;
      res_q     <= '0;
      cout_q    <= 1'b0;
      v_q       <= 1'b0;
    end else begin
      DONE    <= 1'b0;
      SKIPPED <= 1'b0;
      RD_WE   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            // The ALU drive registers hold the latched operands; they stay
            // put through WB and the following IDLE.
            ALU_LEFT  <= RN_VAL;
            ALU_RIGHT <= OP2_VAL;
            ALU_FN    <= OPCODE;
            ALU_CIN   <= cls_in.uses_cin & FLAGS[FLAG_C];
            pass_q    <= cond_pass;
            s_q       <= S_BIT;
            shc_q     <= SHIFTER_C;
            BUSY      <= 1'b1;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q  <= ALU_RESULT;
          cout_q <= ALU_COUT;
          v_q    <= ALU_V;
          state  <= ST_WB;
        end
        ST_WB: begin
          DONE    <= 1'b1;
          SKIPPED <= ~pass_q;
          BUSY    <= 1'b0;
          state   <= ST_IDLE;
          if (pass_q) begin
            // RD_DATA follows the write strobe, so compares leave the
            // previously written result visible.
            if (!cls_q.compare) begin
              RD_WE   <= 1'b1;
              RD_DATA <= res_q;
            end
            if (s_q || cls_q.compare) begin
              FLAGS <= next_flags;
            end
          end
        end
        default: begin
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dp_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_dp_sequencer
// Bench for alu_dp_sequencer. The bench plays the shared ALU, keeps an
// instruction-level reference model (flags, last result, completion edge)
// that a per-cycle compare process checks against, and pins the model with
// hand-computed expectations after each directed instruction.
// ---------------------------------------------------------------------------
module tb_alu_dp_sequencer;
  import alu_pkg::*;

  localparam int         DW = 32;
  localparam logic [3:0] FR = 4'b0000;

  localparam longint TWO32 = 64'h1_0000_0000;
  localparam longint SMAX  = 64'sd2147483647;
  localparam longint SMIN  = -64'sd2147483648;

  logic          CLK;
  logic          RESET_N;
  logic          START;
  logic [3:0]    COND;
  logic [3:0]    OPCODE;
  logic          S_BIT;
  logic [DW-1:0] RN_VAL;
  logic [DW-1:0] OP2_VAL;
  logic          SHIFTER_C;
  logic [DW-1:0] ALU_LEFT;
  logic [DW-1:0] ALU_RIGHT;
  logic [3:0]    ALU_FN;
  logic          ALU_CIN;
  logic [DW-1:0] ALU_RESULT;
  logic          ALU_COUT;
  logic          ALU_V;
  logic          BUSY;
  logic          DONE;
  logic          SKIPPED;
  logic          RD_WE;
  logic [DW-1:0] RD_DATA;
  logic [3:0]    FLAGS;

  alu_dp_sequencer #(.DATA_W(DW), .FLAGS_RST(FR)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .START      (START),
    .COND       (COND),
    .OPCODE     (OPCODE),
    .S_BIT      (S_BIT),
    .RN_VAL     (RN_VAL),
    .OP2_VAL    (OP2_VAL),
    .SHIFTER_C  (SHIFTER_C),
    .ALU_LEFT   (ALU_LEFT),
    .ALU_RIGHT  (ALU_RIGHT),
    .ALU_FN     (ALU_FN),
    .ALU_CIN    (ALU_CIN),
    .ALU_RESULT (ALU_RESULT),
    .ALU_COUT   (ALU_COUT),
    .ALU_V      (ALU_V),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .SKIPPED    (SKIPPED),
    .RD_WE      (RD_WE),
    .RD_DATA    (RD_DATA),
    .FLAGS      (FLAGS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- ALU behaviour (plain integer arithmetic) ----------------
  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        v;
  } alu_t;

  function automatic alu_t ref_alu(input logic [3:0] fn, input logic [31:0] a,
                                   input logic [31:0] b, input logic cin);
    alu_t   o;
    logic   is_add, is_sub;
    logic [31:0] x, y;
    longint ci, u, s;
    o = '0; is_add = 1'b0; is_sub = 1'b0; x = a; y = b; ci = 0;
    case (fn)
      OP_AND, OP_TST: o.r = a & b;
      OP_EOR, OP_TEQ: o.r = a ^ b;
      OP_ORR:         o.r = a | b;
      OP_MOV:         o.r = b;
      OP_BIC:         o.r = a & ~b;
      OP_MVN:         o.r = ~b;
      OP_ADD, OP_CMN: is_add = 1'b1;
      OP_ADC:         begin is_add = 1'b1; ci = longint'(cin); end
      OP_SUB, OP_CMP: begin is_sub = 1'b1; ci = 1; end
      OP_SBC:         begin is_sub = 1'b1; ci = longint'(cin); end
      OP_RSB:         begin is_sub = 1'b1; ci = 1; x = b; y = a; end
      default:        begin is_sub = 1'b1; ci = longint'(cin); x = b; y = a; end // RSC
    endcase
    if (is_add) begin
      u = longint'(x) + longint'(y) + ci;
      s = longint'($signed(x)) + longint'($signed(y)) + ci;
      o.r = u[31:0];
      o.c = (u >= TWO32);
      o.v = (s > SMAX) || (s < SMIN);
    end else if (is_sub) begin
      u = longint'(x) - longint'(y) - (1 - ci);
      s = longint'($signed(x)) - longint'($signed(y)) - (1 - ci);
      o.r = u[31:0];
      o.c = (u >= 0);  // carry = no borrow
      o.v = (s > SMAX) || (s < SMIN);
    end
    return o;
  endfunction

  alu_t alu_out;
  always_comb begin
    alu_out    = ref_alu(ALU_FN, ALU_LEFT, ALU_RIGHT, ALU_CIN);
    ALU_RESULT = alu_out.r;
    ALU_COUT   = alu_out.c;
    ALU_V      = alu_out.v;
  end

  function automatic logic cond_ok(input logic [3:0] cd, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cd)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- instruction-level reference model ----------------
  int          e = 0;           // posedge count
  bit          mvalid = 0;
  logic [3:0]  m_flags;
  logic [31:0] m_rd;
  logic [31:0] m_left, m_right;
  logic [3:0]  m_fn;
  logic        m_cin;
  int          acc_edge, done_edge, free_edge;
  logic        p_we, p_skip;
  logic [31:0] p_rd;
  logic [3:0]  p_flags;
  alu_t        m_alu;
  logic        m_pass, m_cmp, m_arith;

  initial begin
    forever begin
      @(posedge CLK);
      e++;
      if (!RESET_N) begin
        mvalid = 1; m_flags = FR; m_rd = '0;
        m_left = '0; m_right = '0; m_fn = 4'h0; m_cin = 1'b0;
        acc_edge = -10; done_edge = -10; free_edge = e + 1;
      end else if (mvalid) begin
        if (e == done_edge) begin
          m_flags = p_flags;
          if (p_we) m_rd = p_rd;
        end
        if (START && e >= free_edge) begin
          m_cin   = (OPCODE inside {OP_ADC, OP_SBC, OP_RSC}) && m_flags[1];
          m_alu   = ref_alu(OPCODE, RN_VAL, OP2_VAL, m_cin);
          m_pass  = cond_ok(COND, m_flags);
          m_cmp   = (OPCODE >= 4'h8) && (OPCODE <= 4'hB);
          m_arith = ((OPCODE >= 4'h2) && (OPCODE <= 4'h7)) || OPCODE == 4'hA || OPCODE == 4'hB;
          p_skip  = !m_pass;
          p_we    = m_pass && !m_cmp;
          p_rd    = m_alu.r;
          p_flags = m_flags;
          if (m_pass && (S_BIT || m_cmp))
            p_flags = {m_alu.r[31], m_alu.r == 32'h0,
                       m_arith ? m_alu.c : SHIFTER_C,
                       m_arith ? m_alu.v : m_flags[0]};
          m_left = RN_VAL; m_right = OP2_VAL; m_fn = OPCODE;
          acc_edge = e; done_edge = e + 2; free_edge = e + 3;
        end
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (mvalid) begin
        check("cyc_done",    DONE,    e == done_edge);
        check("cyc_skipped", SKIPPED, (e == done_edge) && p_skip);
        check("cyc_rd_we",   RD_WE,   (e == done_edge) && p_we);
        check("cyc_busy",    BUSY,    (e == acc_edge) || (e == acc_edge + 1));
        check("cyc_flags",   FLAGS,   m_flags);
        check("cyc_rd_data", RD_DATA, m_rd);
        check("cyc_alu_l",   ALU_LEFT,  m_left);
        check("cyc_alu_r",   ALU_RIGHT, m_right);
        check("cyc_alu_fn",  ALU_FN,    m_fn);
        check("cyc_alu_cin", ALU_CIN,   m_cin);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Called just after a posedge; returns just after the edge where DONE shows.
  task automatic issue(input logic [3:0] cd, input logic [3:0] op, input logic s,
                       input logic [31:0] rn, input logic [31:0] op2, input logic shc);
    START = 1'b1; COND = cd; OPCODE = op; S_BIT = s;
    RN_VAL = rn; OP2_VAL = op2; SHIFTER_C = shc;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK);
    @(posedge CLK); #1;
  endtask

  task automatic expect_done(input string nm, input logic skip, input logic we,
                             input logic [31:0] rd, input logic [3:0] fl);
    check({nm, "_done"},  DONE,    1'b1);
    check({nm, "_skip"},  SKIPPED, skip);
    check({nm, "_we"},    RD_WE,   we);
    check({nm, "_rd"},    RD_DATA, rd);
    check({nm, "_flags"}, FLAGS,   fl);
  endtask

  int dones;

  initial begin
    RESET_N = 1'b0; START = 1'b0; COND = COND_AL; OPCODE = OP_AND; S_BIT = 1'b0;
    RN_VAL = '0; OP2_VAL = '0; SHIFTER_C = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    check("rst_busy",  BUSY,    1'b0);
    check("rst_done",  DONE,    1'b0);
    check("rst_flags", FLAGS,   FR);
    check("rst_rd",    RD_DATA, 32'h0);
    check("rst_fn",    ALU_FN,  4'h0);
    check("rst_cin",   ALU_CIN, 1'b0);

    issue(COND_AL, OP_ADD, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0);
    expect_done("adds_wrap", 1'b0, 1'b1, 32'h0, 4'b0110);
    issue(COND_AL, OP_MOV, 1'b1, 32'h0, 32'h8000_1234, 1'b0);
    expect_done("movs_neg", 1'b0, 1'b1, 32'h8000_1234, 4'b1000);
    issue(COND_AL, OP_CMP, 1'b0, 32'd5, 32'd5, 1'b0);
    expect_done("cmp_eq", 1'b0, 1'b0, 32'h8000_1234, 4'b0110);
    issue(COND_AL, OP_MOV, 1'b1, 32'h0, 32'h1, 1'b0);
    expect_done("movs_one", 1'b0, 1'b1, 32'h1, 4'b0000);
    issue(COND_EQ, OP_SUB, 1'b1, 32'd10, 32'd3, 1'b0);
    expect_done("subeq_skip", 1'b1, 1'b0, 32'h1, 4'b0000);
    issue(COND_AL, OP_CMP, 1'b0, 32'd2, 32'd2, 1'b0);
    expect_done("cmp_z", 1'b0, 1'b0, 32'h1, 4'b0110);
    issue(COND_EQ, OP_SUB, 1'b1, 32'd10, 32'd3, 1'b0);
    expect_done("subeq_exec", 1'b0, 1'b1, 32'd7, 4'b0010);
    issue(COND_AL, OP_ADC, 1'b0, 32'h10, 32'h20, 1'b0);
    expect_done("adc_c1", 1'b0, 1'b1, 32'h31, 4'b0010);
    check("adc_cin", ALU_CIN, 1'b1);
    issue(COND_AL, OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0);
    expect_done("adds_ovf", 1'b0, 1'b1, 32'h8000_0000, 4'b1001);
    issue(COND_AL, OP_EOR, 1'b1, 32'hF0, 32'hFF, 1'b1);
    expect_done("eors_shc", 1'b0, 1'b1, 32'h0F, 4'b0011);
    issue(COND_GE, OP_MOV, 1'b0, 32'h0, 32'h55, 1'b0);
    expect_done("movge_skip", 1'b1, 1'b0, 32'h0F, 4'b0011);
    issue(COND_LT, OP_MOV, 1'b0, 32'h0, 32'h66, 1'b0);
    expect_done("movlt_exec", 1'b0, 1'b1, 32'h66, 4'b0011);
    issue(COND_NV, OP_MOV, 1'b0, 32'h0, 32'h77, 1'b0);
    expect_done("movnv_skip", 1'b1, 1'b0, 32'h66, 4'b0011);
    issue(COND_HI, OP_SBC, 1'b1, 32'd5, 32'd3, 1'b0);
    expect_done("sbchi", 1'b0, 1'b1, 32'd2, 4'b0010);
    check("sbc_cin", ALU_CIN, 1'b1);

    // START held for six edges: CMP first, then MOVMI which must see N=1.
    dones = 0;
    START = 1'b1; COND = COND_AL; OPCODE = OP_CMP; S_BIT = 1'b0;
    RN_VAL = 32'd1; OP2_VAL = 32'd2; SHIFTER_C = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge CLK); #1;
      if (DONE) dones++;
      if (i == 0) begin COND = COND_MI; OPCODE = OP_MOV; OP2_VAL = 32'hABCD; end
      if (i == 5) START = 1'b0;
    end
    check("b2b_dones", dones, 2);
    check("b2b_rd",    RD_DATA, 32'hABCD);
    check("b2b_flags", FLAGS, 4'b1000);

    // Reset while in EXEC aborts the instruction.
    START = 1'b1; COND = COND_AL; OPCODE = OP_ADD; S_BIT = 1'b1;
    RN_VAL = 32'd1; OP2_VAL = 32'd1; SHIFTER_C = 1'b0;
    @(posedge CLK); #1;
    START = 1'b0; RESET_N = 1'b0;
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    check("rx_done",  DONE,      1'b0);
    check("rx_busy",  BUSY,      1'b0);
    check("rx_we",    RD_WE,     1'b0);
    check("rx_flags", FLAGS,     FR);
    check("rx_rd",    RD_DATA,   32'h0);
    check("rx_left",  ALU_LEFT,  32'h0);
    check("rx_right", ALU_RIGHT, 32'h0);
    check("rx_fn",    ALU_FN,    4'h0);
    check("rx_cin",   ALU_CIN,   1'b0);
    repeat (3) begin
      @(posedge CLK); #1;
      check("rx_no_done", DONE, 1'b0);
    end

    issue(COND_AL, OP_ORR, 1'b1, 32'hF000_0000, 32'h1, 1'b1);
    expect_done("orrs_after_rst", 1'b0, 1'b1, 32'hF000_0001, 4'b1010);

    repeat (3) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
